riscv_fetch_unit: RTL and testbench
===================================

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0, SHALL be the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the prefetch buffer depth (power of two, >=2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL flag a pending instruction-memory read.
REQ-006 imem_addr  output  32  SHALL carry the read address, stable while imem_req=1.
REQ-007 imem_ack  input  1  SHALL flag that imem_rdata is valid this cycle and completes the request.
REQ-008 imem_rdata  input  32  SHALL carry the instruction word.
REQ-009 instr  output  32  SHALL be the FIFO-head instruction, consumed by the datapath.
REQ-010 instr_pc  output  32  SHALL be the fetch address of instr.
REQ-011 instr_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-012 instr_ready  input  1  SHALL pop the head when high together with instr_valid.
REQ-013 redirect  input  1  SHALL request a control-flow change (taken branch/jump).
REQ-014 redirect_pc  input  32  SHALL carry the redirect target.
REQ-015 fetch_misalign  output  1  SHALL flag a sticky misaligned-target error.

Function
REQ-016 State machine SHALL have states IDLE, REQ, DISCARD; imem_req SHALL be 1 exactly in REQ and DISCARD.
REQ-017 At most one memory request SHALL be outstanding; once raised, imem_req and imem_addr SHALL hold until imem_ack.
REQ-018 IDLE->REQ SHALL occur when FIFO count < FIFO_DEPTH and fetch is not halted; imem_addr SHALL load fetch_pc.
REQ-019 On imem_ack in REQ: push {imem_addr, imem_rdata}; fetch_pc += 4 (mod 2^32, 32'hFFFFFFFC wraps to 0); stay in REQ with the new address if post-push/pop count < FIFO_DEPTH, else go to IDLE.
REQ-020 Zero-wait memory with instr_ready=1 SHALL sustain one instruction per cycle.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; pop on empty and push on full SHALL never occur.
REQ-022 instr_valid SHALL be registered state: the first pushed word is visible the cycle after its ack.
REQ-023 redirect SHALL take priority over push and pop: the FIFO is flushed (instr_valid=0 next cycle), and fetch_pc <= redirect_pc.
REQ-024 redirect in REQ without imem_ack SHALL go to DISCARD, keeping the old imem_addr until ack; the acked data SHALL be dropped, then go to REQ at fetch_pc.
REQ-025 redirect in the same cycle as imem_ack SHALL drop that data and go to REQ with imem_addr=redirect_pc.
REQ-026 redirect in DISCARD SHALL update fetch_pc only and remain in DISCARD.

Reset
REQ-027 rst SHALL force: state IDLE, fetch_pc=RESET_PC, FIFO empty, instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_misalign=0, instr=0, instr_pc=0.
REQ-028 rst mid-request SHALL abandon the outstanding request; a late imem_ack after reset release while in IDLE SHALL be ignored.

Configuration
REQ-029 With FETCH_ALIGN_CHECK_EN defined: a redirect_pc with [1:0]!=0 SHALL set fetch_misalign and halt new requests (an outstanding request completes and is discarded) until rst.
REQ-030 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 0, and fetch_misalign SHALL be tied 0.

Verification
REQ-031 Reset: rst=1 -> imem_req=0, instr_valid=0; release -> imem_req=1, imem_addr=0 after one edge.
REQ-032 Zero-wait ack, instr_ready=1 -> instr_pc 0,4,8,12 on consecutive cycles, instr matching memory words.
REQ-033 Back-pressure: instr_ready=0 -> two words buffered (pc 0,4), imem_req=0; instr_ready=1 -> fetch resumes at 8 with no loss or duplication.
REQ-034 Ack delayed 3 cycles at addr 4, redirect_pc=32'h100 asserted in wait -> addr 4 data dropped, next imem_addr=32'h100, first instr_pc=32'h100.
REQ-035 redirect_pc=32'h40 coincident with imem_ack -> acked word never appears; next imem_addr=32'h40.
REQ-036 redirect_pc=32'h102: with macro -> fetch_misalign=1, no further imem_req; without -> fetch from 32'h100.

Source files
------------

// File: rtl/riscv_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/ack channel plus the
// valid/ready instruction stream handed to the datapath.
interface riscv_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// RISC-V instruction fetch unit: single-outstanding memory requester feeding a
// prefetch FIFO. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  riscv_fetch_unit_if.master        bus,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  output logic                      fetch_misalign
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_addr;
  logic              req_q;
  logic [31:0]       buf_pc   [FIFO_DEPTH];
  logic [31:0]       buf_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              valid;
  logic              push;
  logic              pop;
  logic [31:0]       target;
  logic [31:0]       pc_plus4;
  logic [31:0]       resume_pc;
  logic              misalign_new;
  logic              halted;
  logic              halt_next;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target       = redirect_pc;
  assign misalign_new = redirect && (redirect_pc[1:0] != 2'b00);
  assign halted       = misalign_q;

  // Sticky until reset; it also blocks every future request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (misalign_new) begin
      misalign_q <= 1'b1;
    end
  end

  assign fetch_misalign = misalign_q;
`else
  logic unused_low_bits;

  assign target          = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misalign_new    = 1'b0;
  assign halted          = 1'b0;
  assign fetch_misalign  = 1'b0;
`endif

  assign halt_next = halted | misalign_new;
  assign valid     = (count != '0);
  assign push      = (state == REQ) && bus.imem_ack && !redirect;
  assign pop       = valid && bus.instr_ready && !redirect;
  assign pc_plus4  = fetch_pc + 32'd4;
  assign resume_pc = redirect ? target : fetch_pc;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // fetch_pc tracks the outstanding (or next) request address; it only
  // advances when a request's data is actually accepted into the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target;
            if (!halt_next) begin
              state    <= REQ;
              req_q    <= 1'b1;
              req_addr <= target;
            end
          end else if ((count < DEPTH_C) && !halted) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= target;
            if (!bus.imem_ack) begin
              state <= DISCARD;
            end else if (!halt_next) begin
              req_addr <= target;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end else if (bus.imem_ack) begin
            fetch_pc <= pc_plus4;
            if ((count_next < DEPTH_C) && !halted) begin
              req_addr <= pc_plus4;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect) begin
            fetch_pc <= target;
          end
          // The stale request still has to be acked before a new one may start.
          if (bus.imem_ack) begin
            if (!halt_next) begin
              state    <= REQ;
              req_q    <= 1'b1;
              req_addr <= resume_pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO; a redirect empties it regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc[i]   <= 32'h0;
        buf_data[i] <= 32'h0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]   <= req_addr;
        buf_data[wr_ptr] <= bus.imem_rdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = req_addr;
  assign bus.instr       = buf_data[rd_ptr];
  assign bus.instr_pc    = buf_pc[rd_ptr];
  assign bus.instr_valid = valid;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed self-checking bench for riscv_fetch_unit; memory returns addr ^ 32'hDEAD0000.
// Honours FETCH_ALIGN_CHECK_EN for the misaligned-redirect case.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;
  logic        auto_ack;
  logic        man_ack;
  logic        ready;
  logic        mon_en;
  int          checks;
  int          failures;
  logic [31:0] pop_q[$];

  riscv_fetch_unit_if bus();

  riscv_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  assign bus.imem_ack    = auto_ack ? bus.imem_req : man_ack;
  assign bus.imem_rdata  = bus.imem_addr ^ 32'hDEAD0000;
  assign bus.instr_ready = ready;

  // Record every instruction the datapath consumes at the coming edge.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.instr_valid && bus.instr_ready)
      pop_q.push_back(bus.instr_pc);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic ack,
                               input logic rd, input logic [31:0] rpc);
    rst         = r;
    ready       = rdy;
    man_ack     = ack;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    auto_ack    = 1'b0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    ready       = 1'b0;
    man_ack     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state and first request
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_req",      bus.imem_req,    0);
    checkOutput("rst_valid",    bus.instr_valid, 0);
    checkOutput("rst_addr",     bus.imem_addr,   0);
    checkOutput("rst_misalign", fetch_misalign,  0);
    checkOutput("rst_instr",    bus.instr,       0);
    checkOutput("rst_instr_pc", bus.instr_pc,    0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rel_req",  bus.imem_req,  1);
    checkOutput("rel_addr", bus.imem_addr, 0);

    // Zero-wait memory, one instruction per cycle
    auto_ack = 1'b1;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("zw_pc0",    bus.instr_pc, 32'h0);
    checkOutput("zw_instr0", bus.instr,    32'hDEAD0000);
    checkOutput("zw_valid0", bus.instr_valid, 1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("zw_pc4",    bus.instr_pc, 32'h4);
    checkOutput("zw_instr4", bus.instr,    32'hDEAD0004);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("zw_pc8",    bus.instr_pc, 32'h8);
    checkOutput("zw_instr8", bus.instr,    32'hDEAD0008);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("zw_pc12",    bus.instr_pc, 32'hC);
    checkOutput("zw_instr12", bus.instr,    32'hDEAD000C);

    // Back-pressure fills the FIFO, then drains without loss or duplication
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp_req_off", bus.imem_req,    0);
    checkOutput("bp_valid",   bus.instr_valid, 1);
    checkOutput("bp_head",    bus.instr_pc,    32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp_hold_req", bus.imem_req, 0);
    pop_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0);
    mon_en = 1'b0;
    checkOutput("bp_pop_count", 32'(pop_q.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      checkOutput("bp_pop_pc", (i < pop_q.size()) ? pop_q[i] : 32'hFFFFFFFF, 32'(4 * i));
    auto_ack = 1'b0;

    // Redirect while waiting on a slow ack at addr 4
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dly_addr4", bus.imem_addr, 32'h4);
    applyStimulus(0, 1, 0, 1, 32'h100);
    checkOutput("dly_disc_req",   bus.imem_req,    1);
    checkOutput("dly_disc_addr",  bus.imem_addr,   32'h4);
    checkOutput("dly_disc_valid", bus.instr_valid, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("dly_wait_addr", bus.imem_addr, 32'h4);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dly_new_addr", bus.imem_addr,   32'h100);
    checkOutput("dly_dropped",  bus.instr_valid, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dly_first_pc",    bus.instr_pc, 32'h100);
    checkOutput("dly_first_instr", bus.instr,    32'hDEAD0100);

    // Redirect coincident with ack drops the acked word
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h40);
    checkOutput("co_addr",  bus.imem_addr,   32'h40);
    checkOutput("co_req",   bus.imem_req,    1);
    checkOutput("co_valid", bus.instr_valid, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("co_pc",    bus.instr_pc, 32'h40);
    checkOutput("co_instr", bus.instr,    32'hDEAD0040);

    // Redirect while already discarding only retargets the resume address
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 32'h100);
    applyStimulus(0, 1, 0, 1, 32'h200);
    checkOutput("dd_req",  bus.imem_req,  1);
    checkOutput("dd_addr", bus.imem_addr, 32'h0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dd_resume", bus.imem_addr, 32'h200);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dd_pc", bus.instr_pc, 32'h200);

    // Reset mid-request, then a late ack right after release
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("mr_req", bus.imem_req, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("late_valid", bus.instr_valid, 0);
    checkOutput("late_req",   bus.imem_req,    1);
    checkOutput("late_addr",  bus.imem_addr,   32'h0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("late_still_empty", bus.instr_valid, 0);

    // Misaligned redirect target
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("mis_flag",  fetch_misalign,  1);
    checkOutput("mis_req",   bus.imem_req,    0);
    checkOutput("mis_valid", bus.instr_valid, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("mis_halt_req",  bus.imem_req,   0);
    checkOutput("mis_halt_flag", fetch_misalign, 1);
`else
    checkOutput("mis_flag", fetch_misalign, 0);
    checkOutput("mis_addr", bus.imem_addr,  32'h100);
    checkOutput("mis_req",  bus.imem_req,   1);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("mis_pc",    bus.instr_pc, 32'h100);
    checkOutput("mis_instr", bus.instr,    32'hDEAD0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
